plugin_collect_ctrl: RTL and testbench
======================================

PLUGIN_COLLECT_CTRL -- requirements
Module: plugin_collect_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_PLUGINS, 5, number of plugins sequenced.
- WARP_WIDTH, 16, signed warp component width.
- ERROR_WIDTH, 32, unsigned plugin error width.
- TIMEOUT_CYCLES, 15, maximum WAIT cycles per plugin.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req  in  1  run request pulse.
- busy  out  1  high from run accept until result handshake completes.
- plugin_start  out  NUM_PLUGINS  one-hot start pulse.
- plugin_valid  in  NUM_PLUGINS  per-plugin valid.
- plugin_warp_x/_y/_z  in  NUM_PLUGINS*WARP_WIDTH  packed, plugin i at [i*W +: W].
- plugin_error  in  NUM_PLUGINS*ERROR_WIDTH  packed likewise.
- err_threshold  in  ERROR_WIDTH  pass limit.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accept.
- sum_x/_y/_z  out  WARP_WIDTH  saturated signed sums.
- error_sum  out  ERROR_WIDTH  saturated unsigned sum.
- err_exceed  out  1  error_sum > err_threshold.
- ovf_flags  out  3  sticky saturation, bit0 X, bit1 Y, bit2 Z.
- timeout_mask  out  NUM_PLUGINS  plugins skipped by timeout.

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT, NEXT and DONE.
REQ-005 In IDLE, req=1 SHALL clear all accumulators, flags and timeout_mask, set index i=0, and move to ISSUE on the next cycle.
REQ-006 ISSUE SHALL assert plugin_start[i] for exactly one cycle, then move to WAIT with wait_cnt=0.
REQ-007 plugin_valid[i] SHALL be sampled only in WAIT, never in the ISSUE cycle, so a valid held high from a previous run is not mistaken for a new capture.
REQ-008 In WAIT, plugin_valid[i]=1 SHALL capture plugin i's warp and error into the accumulators in that cycle, then move to NEXT; otherwise wait_cnt SHALL increment.
REQ-009 NEXT SHALL go to ISSUE with i+1 if i<NUM_PLUGINS-1, else to DONE.
REQ-010 Warp accumulation SHALL be a signed add clamped to [-2^(W-1), 2^(W-1)-1]; on clamp the matching ovf_flags bit SHALL set and stay set until the next run.
REQ-011 error_sum SHALL be an unsigned add saturating at all-ones.
REQ-012 err_exceed SHALL be a registered strict greater-than comparison, valid whenever result_valid=1.
REQ-013 DONE SHALL hold result_valid=1 and all result outputs stable until result_ready=1; that cycle SHALL return to IDLE with result_valid=0.
REQ-014 req SHALL be ignored while busy=1.
REQ-015 req=1 in the same cycle as a DONE handshake SHALL be ignored, since the FSM is not in IDLE.
REQ-016 Minimum run latency from req to result_valid SHALL be 3*NUM_PLUGINS+1 cycles when every plugin is valid on its first WAIT cycle.

Reset
REQ-017 rst=1 SHALL force IDLE and zero every output, accumulator, counter and index on the next edge, including mid-run.
REQ-018 plugin_start SHALL be 0 in the cycle after reset.
REQ-019 A partially accumulated run interrupted by reset SHALL be discarded and produce no result_valid.

Configuration
REQ-020 With PLUGIN_COLLECT_TIMEOUT_EN defined, a WAIT reaching wait_cnt=TIMEOUT_CYCLES without valid SHALL set timeout_mask[i], add nothing, and go to NEXT.
REQ-021 With PLUGIN_COLLECT_TIMEOUT_EN undefined, WAIT SHALL wait indefinitely, and timeout_mask SHALL be tied to 0.

Verification
REQ-022 All five plugins valid on their first WAIT cycle with X=0x0100, Y=0xFF00, Z=0x0010, errors 1..5, err_threshold=14 -> result_valid exactly 16 cycles after req; sum_x=0x0500, sum_y=0xFB00, sum_z=0x0050, error_sum=15, err_exceed=1, ovf_flags=0.
REQ-023 Two plugins X=0x7FFF, three plugins X=0, Y=0x8000 on all five -> sum_x=0x7FFF, sum_y=0x8000, ovf_flags=3'b011.
REQ-024 Macro defined, plugin 2 never valid, others valid -> plugin 2 WAIT lasts 16 cycles, timeout_mask=5'b00100, and plugin 2 contributes nothing to the sums.
REQ-025 result_ready held low 10 cycles in DONE with req pulsed meanwhile -> outputs stable, busy=1, no second run; result_ready=1 -> IDLE the next cycle.
REQ-026 rst pulsed in WAIT of plugin 3 -> all outputs 0 the next cycle and no result_valid; a new req gives a clean run matching REQ-022.
REQ-027 plugin_valid held high from a previous run, then req -> no capture occurs during ISSUE, and the totals match a fresh run.

Source files
------------

// File: rtl/plugin_collect_ctrl.sv
// ============================================================================
// plugin_collect_ctrl : sequences NUM_PLUGINS plugins one at a time and
//   accumulates their warp/error into saturated sums (optional macro:
//   PLUGIN_COLLECT_TIMEOUT_EN enables per-plugin WAIT timeout)
// Revision: 1.0
// ============================================================================
`default_nettype none

module plugin_collect_ctrl #(
    parameter int NUM_PLUGINS    = 5,
    parameter int WARP_WIDTH     = 16,
    parameter int ERROR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req,
    output logic                               busy,
    output logic [NUM_PLUGINS-1:0]             plugin_start,
    input  logic [NUM_PLUGINS-1:0]             plugin_valid,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_x,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_y,
    input  logic [NUM_PLUGINS*WARP_WIDTH-1:0]  plugin_warp_z,
    input  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error,
    input  logic [ERROR_WIDTH-1:0]             err_threshold,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [WARP_WIDTH-1:0]              sum_x,
    output logic [WARP_WIDTH-1:0]              sum_y,
    output logic [WARP_WIDTH-1:0]              sum_z,
    output logic [ERROR_WIDTH-1:0]             error_sum,
    output logic                               err_exceed,
    output logic [2:0]                         ovf_flags,
    output logic [NUM_PLUGINS-1:0]             timeout_mask
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int                     IDX_W    = (NUM_PLUGINS > 1) ? $clog2(NUM_PLUGINS) : 1;
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_PLUGINS - 1);
    localparam logic [NUM_PLUGINS-1:0] START0   = NUM_PLUGINS'(1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_PLUGINS-1:0]  r_start;
    logic                    r_busy;
    logic                    r_rvalid;
    logic [WARP_WIDTH-1:0]   r_sum_x, r_sum_y, r_sum_z;
    logic [ERROR_WIDTH-1:0]  r_err_sum;
    logic                    r_err_exceed;
    logic [2:0]              r_ovf;

`ifdef PLUGIN_COLLECT_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCNT_W-1:0]       r_wait_cnt;
    logic [NUM_PLUGINS-1:0]  r_timeout_mask;
`endif

    // Returns {clamped, sum}; overflow shows as disagreement of the two top bits.
    function automatic logic [WARP_WIDTH:0] sat_add_s(input logic [WARP_WIDTH-1:0] a,
                                                      input logic [WARP_WIDTH-1:0] b);
        logic [WARP_WIDTH:0] s;
        s = {a[WARP_WIDTH-1], a} + {b[WARP_WIDTH-1], b};
        if (s[WARP_WIDTH] != s[WARP_WIDTH-1])
            sat_add_s = {1'b1, s[WARP_WIDTH], {(WARP_WIDTH-1){~s[WARP_WIDTH]}}};
        else
            sat_add_s = {1'b0, s[WARP_WIDTH-1:0]};
    endfunction

    logic [WARP_WIDTH:0]    w_add_x, w_add_y, w_add_z;
    logic [ERROR_WIDTH:0]   w_err_ext;
    logic [ERROR_WIDTH-1:0] w_err_sat;

    always_comb begin
        w_add_x   = sat_add_s(r_sum_x, plugin_warp_x[r_idx*WARP_WIDTH +: WARP_WIDTH]);
        w_add_y   = sat_add_s(r_sum_y, plugin_warp_y[r_idx*WARP_WIDTH +: WARP_WIDTH]);
        w_add_z   = sat_add_s(r_sum_z, plugin_warp_z[r_idx*WARP_WIDTH +: WARP_WIDTH]);
        w_err_ext = {1'b0, r_err_sum} + {1'b0, plugin_error[r_idx*ERROR_WIDTH +: ERROR_WIDTH]};
        w_err_sat = w_err_ext[ERROR_WIDTH] ? '1 : w_err_ext[ERROR_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_start      <= '0;
            r_busy       <= 1'b0;
            r_rvalid     <= 1'b0;
            r_sum_x      <= '0;
            r_sum_y      <= '0;
            r_sum_z      <= '0;
            r_err_sum    <= '0;
            r_err_exceed <= 1'b0;
            r_ovf        <= '0;
`ifdef PLUGIN_COLLECT_TIMEOUT_EN
            r_wait_cnt     <= '0;
            r_timeout_mask <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_sum_x      <= '0;
                        r_sum_y      <= '0;
                        r_sum_z      <= '0;
                        r_err_sum    <= '0;
                        r_err_exceed <= 1'b0;
                        r_ovf        <= '0;
`ifdef PLUGIN_COLLECT_TIMEOUT_EN
                        r_timeout_mask <= '0;
`endif
                        r_idx        <= '0;
                        r_start      <= START0;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= '0;
`ifdef PLUGIN_COLLECT_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (plugin_valid[r_idx]) begin
                        r_sum_x   <= w_add_x[WARP_WIDTH-1:0];
                        r_sum_y   <= w_add_y[WARP_WIDTH-1:0];
                        r_sum_z   <= w_add_z[WARP_WIDTH-1:0];
                        r_err_sum <= w_err_sat;
                        r_ovf     <= r_ovf | {w_add_z[WARP_WIDTH], w_add_y[WARP_WIDTH], w_add_x[WARP_WIDTH]};
                        r_state   <= S_NEXT;
                    end
`ifdef PLUGIN_COLLECT_TIMEOUT_EN
                    else if (r_wait_cnt == WCNT_W'(TIMEOUT_CYCLES)) begin
                        r_timeout_mask[r_idx] <= 1'b1;
                        r_state               <= S_NEXT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
`endif
                end
                S_NEXT: begin
                    if (r_idx == LAST_IDX) begin
                        r_err_exceed <= (r_err_sum > err_threshold);
                        r_rvalid     <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_start <= START0 << (r_idx + IDX_W'(1));
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_rvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign plugin_start = r_start;
    assign result_valid = r_rvalid;
    assign sum_x        = r_sum_x;
    assign sum_y        = r_sum_y;
    assign sum_z        = r_sum_z;
    assign error_sum    = r_err_sum;
    assign err_exceed   = r_err_exceed;
    assign ovf_flags    = r_ovf;
`ifdef PLUGIN_COLLECT_TIMEOUT_EN
    assign timeout_mask = r_timeout_mask;
`else
    assign timeout_mask = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_plugin_collect_ctrl.sv
// ============================================================================
// tb_plugin_collect_ctrl : directed self-checking bench for plugin_collect_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_plugin_collect_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         busy;
    logic [4:0]   plugin_start;
    logic [4:0]   plugin_valid;
    logic [79:0]  plugin_warp_x, plugin_warp_y, plugin_warp_z;
    logic [159:0] plugin_error;
    logic [31:0]  err_threshold;
    logic         result_valid;
    logic         result_ready;
    logic [15:0]  sum_x, sum_y, sum_z;
    logic [31:0]  error_sum;
    logic         err_exceed;
    logic [2:0]   ovf_flags;
    logic [4:0]   timeout_mask;

    int total = 0;
    int bad   = 0;

    logic [4:0] en_mask   = 5'b11111;
    logic [4:0] hold_mask = 5'b00000;
    logic [4:0] seen_start;

    plugin_collect_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .busy          (busy),
        .plugin_start  (plugin_start),
        .plugin_valid  (plugin_valid),
        .plugin_warp_x (plugin_warp_x),
        .plugin_warp_y (plugin_warp_y),
        .plugin_warp_z (plugin_warp_z),
        .plugin_error  (plugin_error),
        .err_threshold (err_threshold),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .sum_x         (sum_x),
        .sum_y         (sum_y),
        .sum_z         (sum_z),
        .error_sum     (error_sum),
        .err_exceed    (err_exceed),
        .ovf_flags     (ovf_flags),
        .timeout_mask  (timeout_mask)
    );

    always #5 clk = ~clk;

    // Plugin model: answers a start pulse with valid on the following cycle.
    initial plugin_valid = 5'b0;
    always @(posedge clk) begin
        seen_start = plugin_start;
        #2 plugin_valid = (seen_start & en_mask) | hold_mask;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses req and returns the number of cycles until result_valid is seen.
    task automatic run(output int lat);
        req = 1'b1;
        tick();
        req = 1'b0;
        lat = 1;
        while (!result_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic load_case_a();
        plugin_warp_x = {5{16'h0100}};
        plugin_warp_y = {5{16'hFF00}};
        plugin_warp_z = {5{16'h0010}};
        plugin_error  = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        err_threshold = 32'd14;
    endtask

    task automatic check_case_a(input string tag, input int lat);
        chk({tag, "_lat"},  64'(lat), 64'd16);
        chk({tag, "_x"},    64'(sum_x), 64'h0500);
        chk({tag, "_y"},    64'(sum_y), 64'hFB00);
        chk({tag, "_z"},    64'(sum_z), 64'h0050);
        chk({tag, "_err"},  64'(error_sum), 64'd15);
        chk({tag, "_exc"},  64'(err_exceed), 64'd1);
        chk({tag, "_ovf"},  64'(ovf_flags), 64'd0);
        chk({tag, "_tmo"},  64'(timeout_mask), 64'd0);
    endtask

    initial begin
        int lat;
        int cnt;
        logic saw_rv;

        rst = 1'b1; req = 1'b0; result_ready = 1'b0;
        plugin_warp_x = '0; plugin_warp_y = '0; plugin_warp_z = '0;
        plugin_error = '0; err_threshold = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_rv",    64'(result_valid), 64'd0);
        chk("rst_start", 64'(plugin_start), 64'd0);
        chk("rst_sums",  64'({sum_x, sum_y, sum_z}), 64'd0);
        chk("rst_err",   64'({error_sum, err_exceed, ovf_flags}), 64'd0);

        // Nominal run, then a stalled handshake with a stray req.
        load_case_a();
        run(lat);
        check_case_a("A", lat);
        chk("A_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) req = 1'b1;
            tick();
            req = 1'b0;
        end
        chk("stall_rv",    64'(result_valid), 64'd1);
        chk("stall_busy",  64'(busy), 64'd1);
        chk("stall_sums",  64'({sum_x, sum_y, sum_z}), 64'h0500_FB00_0050);
        chk("stall_err",   64'(error_sum), 64'd15);
        chk("stall_start", 64'(plugin_start), 64'd0);
        req = 1'b1;
        handshake();
        req = 1'b0;
        chk("hs_rv",   64'(result_valid), 64'd0);
        chk("hs_busy", 64'(busy), 64'd0);
        tick();
        chk("hs_norun_start", 64'(plugin_start), 64'd0);
        chk("hs_norun_busy",  64'(busy), 64'd0);

        // Positive and negative clamping.
        plugin_warp_x = {16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
        plugin_warp_y = {5{16'h8000}};
        plugin_warp_z = '0;
        plugin_error  = '0;
        err_threshold = 32'd0;
        run(lat);
        chk("B_x",   64'(sum_x), 64'h7FFF);
        chk("B_y",   64'(sum_y), 64'h8000);
        chk("B_z",   64'(sum_z), 64'h0000);
        chk("B_ovf", 64'(ovf_flags), 64'b011);
        chk("B_exc", 64'(err_exceed), 64'd0);
        handshake();

        // Error saturation; flags from the previous run must be cleared.
        plugin_warp_x = {16'h0001, 16'hFFFF, 16'h0003, 16'hFFFE, 16'h0005};
        plugin_warp_y = '0;
        plugin_warp_z = {5{16'hF000}};
        plugin_error  = {5{32'hFFFF_FFF0}};
        err_threshold = 32'hFFFF_FFFE;
        run(lat);
        chk("C_x",   64'(sum_x), 64'h0006);
        chk("C_z",   64'(sum_z), 64'hB000);
        chk("C_err", 64'(error_sum), 64'hFFFF_FFFF);
        chk("C_exc", 64'(err_exceed), 64'd1);
        chk("C_ovf", 64'(ovf_flags), 64'd0);
        handshake();

        // Reset while waiting on plugin 3.
        load_case_a();
        en_mask = 5'b10111;
        req = 1'b1;
        tick();
        req = 1'b0;
        cnt = 0;
        while (!plugin_start[3] && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("D_reach_p3", 64'(plugin_start[3]), 64'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("D_rst_busy",  64'(busy), 64'd0);
        chk("D_rst_rv",    64'(result_valid), 64'd0);
        chk("D_rst_start", 64'(plugin_start), 64'd0);
        chk("D_rst_vals",  64'({sum_x, sum_y, sum_z, err_exceed, ovf_flags}), 64'd0);
        chk("D_rst_err",   64'(error_sum), 64'd0);
        en_mask = 5'b11111;
        saw_rv = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            saw_rv = saw_rv | result_valid;
        end
        chk("D_no_rv", 64'(saw_rv), 64'd0);
        run(lat);
        check_case_a("D", lat);
        handshake();

        // Valid stuck high from before the run must not be captured early.
        en_mask   = 5'b00000;
        hold_mask = 5'b11111;
        tick(); tick();
        run(lat);
        check_case_a("E", lat);
        handshake();
        hold_mask = 5'b00000;
        en_mask   = 5'b11111;
        tick(); tick();

`ifdef PLUGIN_COLLECT_TIMEOUT_EN
        en_mask = 5'b11011;
        run(lat);
        chk("T_lat",  64'(lat), 64'd31);
        chk("T_mask", 64'(timeout_mask), 64'b00100);
        chk("T_x",    64'(sum_x), 64'h0400);
        chk("T_y",    64'(sum_y), 64'hFC00);
        chk("T_z",    64'(sum_z), 64'h0040);
        chk("T_err",  64'(error_sum), 64'd12);
        chk("T_exc",  64'(err_exceed), 64'd0);
        handshake();
        en_mask = 5'b11111;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
